// File: rtl/text_console_writer_pkg.sv
// Shared constants, FSM encoding and cell packing for the text console writer.
// Build option: define VBLANK_SYNC_EN to hold RAM writes until vertical blanking.
package vga_text_pkg;

  localparam logic [7:0] CC_BS      = 8'h08;
  localparam logic [7:0] CC_LF      = 8'h0A;
  localparam logic [7:0] CC_FF      = 8'h0C;
  localparam logic [7:0] CC_CR      = 8'h0D;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_CLEAR_ALL,
    ST_SCROLL_RD,
    ST_SCROLL_WAIT,
    ST_SCROLL_WR,
    ST_CLEAR_ROW
  } state_t;

  function automatic logic [15:0] pack_cell(input logic [7:0] attr, input logic [7:0] ch);
    return {attr, ch};
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Byte-stream handshake plus the CPU-side text RAM port of the console writer.
// master = the writer (stream sink, RAM bus owner); slave = feeder and RAM.
interface text_console_writer_if;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_data;
  logic [7:0]  char_attr;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_oe;
  logic [15:0] cpu_dataOut;
  logic [15:0] cpu_dataIn;

  modport master (
    input  char_valid, char_data, char_attr, cpu_dataIn,
    output char_ready, cpu_addr, cpu_we, cpu_oe, cpu_dataOut
  );

  modport slave (
    output char_valid, char_data, char_attr, cpu_dataIn,
    input  char_ready, cpu_addr, cpu_we, cpu_oe, cpu_dataOut
  );
endinterface

// File: rtl/text_console_writer_vblank_sync.sv
// Two-flop synchroniser bringing the pixel-domain vBlank into cpu_clk.
module vblank_sync (
  input  logic clk,
  input  logic d,
  output logic q
);
  logic vblank_p0;
  logic vblank_p1;

  always_ff @(posedge clk) begin
    vblank_p0 <= d;
    vblank_p1 <= vblank_p0;
  end

  assign q = vblank_p1;
endmodule

// File: rtl/text_console_writer.sv
// Text console writer: byte stream in, cursor tracking, control codes and hardware scroll
// through the text RAM CPU port. Build option: VBLANK_SYNC_EN gates writes to vBlank.
module text_console_writer
  import vga_text_pkg::*;
#(
  parameter int         N_COL        = 80,
  parameter int         N_ROW        = 30,
  parameter logic [7:0] CLEAR_ATTR   = 8'h07,
  parameter int         READ_LATENCY = 1
) (
  input  logic                   cpu_clk,
  input  logic                   rst_p,
  text_console_writer_if.master  bus,
  input  logic                   vBlank,
  output logic [6:0]             cursor_col,
  output logic [4:0]             cursor_row,
  output logic                   busy
);

  localparam logic [15:0] N_COL16       = 16'(N_COL);
  localparam logic [15:0] COL_LAST16    = 16'(N_COL - 1);
  localparam logic [15:0] LAST_CELL     = 16'(N_COL * N_ROW - 1);
  localparam logic [15:0] LAST_ROW_BASE = 16'((N_ROW - 1) * N_COL);
  localparam logic [6:0]  COL_LAST      = 7'(N_COL - 1);
  localparam logic [4:0]  ROW_LAST      = 5'(N_ROW - 1);
  localparam logic [7:0]  WAIT_LAST     = 8'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [15:0] CLEAR_CELL    = pack_cell(CLEAR_ATTR, SPACE_CHAR);

  state_t      state, state_n;
  logic [15:0] ptr, ptr_n;
  logic [15:0] lin, lin_n;
  logic [6:0]  col, col_n;
  logic [4:0]  row, row_n;
  logic        hold, hold_n;
  logic [7:0]  wait_cnt, wait_n;
  logic [7:0]  byte_q, attr_q;
  logic [15:0] rd_q;
  logic        latch;
  logic        wr_go;
  logic        rdy, we, oe;
  logic [15:0] addr, dout;

`ifdef VBLANK_SYNC_EN
  logic vb_sync;
  vblank_sync u_vblank_sync (.clk(cpu_clk), .d(vBlank), .q(vb_sync));
  assign wr_go = vb_sync;
`else
  logic unused_vblank;
  assign unused_vblank = vBlank;
  assign wr_go = 1'b1;
`endif

  always_ff @(posedge cpu_clk) begin
    if (rst_p) begin
      state    <= ST_CLEAR_ALL;
      ptr      <= '0;
      lin      <= '0;
      col      <= '0;
      row      <= '0;
      hold     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      lin      <= lin_n;
      col      <= col_n;
      row      <= row_n;
      hold     <= hold_n;
      wait_cnt <= wait_n;
    end
  end

  // Read data is captured on the first write attempt so a stalled write keeps it stable.
  always_ff @(posedge cpu_clk) begin
    if (latch) begin
      byte_q <= bus.char_data;
      attr_q <= bus.char_attr;
    end
    if (state == ST_SCROLL_WR && !hold) rd_q <= bus.cpu_dataIn;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    lin_n   = lin;
    col_n   = col;
    row_n   = row;
    hold_n  = hold;
    wait_n  = wait_cnt;
    latch   = 1'b0;
    rdy     = 1'b0;
    we      = 1'b0;
    oe      = 1'b0;
    addr    = '0;
    dout    = '0;
    case (state)
      ST_IDLE: begin
        rdy = 1'b1;
        if (bus.char_valid) begin
          latch   = 1'b1;
          state_n = ST_PUT;
        end
      end
      ST_PUT: begin
        addr = lin;
        if (byte_q >= SPACE_CHAR) begin
          dout = pack_cell(attr_q, byte_q);
          we   = wr_go;
          if (wr_go) begin
            state_n = ST_IDLE;
            if (col == COL_LAST) begin
              col_n = '0;
              if (row == ROW_LAST) begin
                lin_n   = lin - COL_LAST16;
                ptr_n   = N_COL16;
                state_n = ST_SCROLL_RD;
              end else begin
                lin_n = lin + 16'd1;
                row_n = row + 5'd1;
              end
            end else begin
              col_n = col + 7'd1;
              lin_n = lin + 16'd1;
            end
          end
        end else begin
          state_n = ST_IDLE;
          case (byte_q)
            CC_CR: begin
              col_n = '0;
              lin_n = lin - {9'b0, col};
            end
            CC_LF: begin
              if (row == ROW_LAST) begin
                ptr_n   = N_COL16;
                state_n = ST_SCROLL_RD;
              end else begin
                row_n = row + 5'd1;
                lin_n = lin + N_COL16;
              end
            end
            CC_BS: begin
              if (col != '0) begin
                addr = lin - 16'd1;
                dout = CLEAR_CELL;
                we   = wr_go;
                if (wr_go) begin
                  col_n = col - 7'd1;
                  lin_n = lin - 16'd1;
                end else begin
                  state_n = ST_PUT;
                end
              end
            end
            CC_FF: begin
              ptr_n   = '0;
              state_n = ST_CLEAR_ALL;
            end
            default: ;
          endcase
        end
      end
      ST_CLEAR_ALL: begin
        addr = ptr;
        dout = CLEAR_CELL;
        we   = wr_go;
        if (wr_go) begin
          if (ptr == LAST_CELL) begin
            ptr_n   = '0;
            lin_n   = '0;
            col_n   = '0;
            row_n   = '0;
            state_n = ST_IDLE;
          end else begin
            ptr_n = ptr + 16'd1;
          end
        end
      end
      ST_SCROLL_RD: begin
        oe      = 1'b1;
        addr    = ptr;
        hold_n  = 1'b0;
        wait_n  = '0;
        state_n = (READ_LATENCY > 1) ? ST_SCROLL_WAIT : ST_SCROLL_WR;
      end
      ST_SCROLL_WAIT: begin
        addr = ptr;
        if (wait_cnt == WAIT_LAST) state_n = ST_SCROLL_WR;
        else                       wait_n  = wait_cnt + 8'd1;
      end
      ST_SCROLL_WR: begin
        addr = ptr - N_COL16;
        dout = hold ? rd_q : bus.cpu_dataIn;
        we   = wr_go;
        if (wr_go) begin
          hold_n = 1'b0;
          if (ptr == LAST_CELL) begin
            ptr_n   = LAST_ROW_BASE;
            state_n = ST_CLEAR_ROW;
          end else begin
            ptr_n   = ptr + 16'd1;
            state_n = ST_SCROLL_RD;
          end
        end else begin
          hold_n = 1'b1;
        end
      end
      ST_CLEAR_ROW: begin
        addr = ptr;
        dout = CLEAR_CELL;
        we   = wr_go;
        if (wr_go) begin
          if (ptr == LAST_CELL) begin
            ptr_n   = '0;
            state_n = ST_IDLE;
          end else begin
            ptr_n = ptr + 16'd1;
          end
        end
      end
      default: state_n = ST_CLEAR_ALL;
    endcase
    // The bus stays quiet for as long as reset is held.
    if (rst_p) begin
      rdy  = 1'b0;
      we   = 1'b0;
      oe   = 1'b0;
      addr = '0;
      dout = '0;
    end
  end

  assign bus.char_ready  = rdy;
  assign bus.cpu_we      = we;
  assign bus.cpu_oe      = oe;
  assign bus.cpu_addr    = addr;
  assign bus.cpu_dataOut = dout;
  assign cursor_col      = col;
  assign cursor_row      = row;
  assign busy            = rst_p || (state != ST_IDLE);

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: RAM model on the CPU port, screen-level reference model.
module tb_text_console_writer;

  localparam int LIMIT = 10000;

  logic       cpu_clk = 1'b0;
  logic       rst_p   = 1'b1;
  logic       vBlank  = 1'b1;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  text_console_writer_if bus();

  text_console_writer dut (
    .cpu_clk    (cpu_clk),
    .rst_p      (rst_p),
    .bus        (bus),
    .vBlank     (vBlank),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  // RAM with one cycle of read latency, plus a log of every bus access
  logic [15:0] mem [0:2399];
  logic [31:0] obs_w[$];
  int          obs_r[$];
  int          overlap = 0;

  always @(posedge cpu_clk) begin
    if (bus.cpu_we && bus.cpu_addr < 16'd2400) mem[bus.cpu_addr] <= bus.cpu_dataOut;
    if (bus.cpu_oe) bus.cpu_dataIn <= mem[bus.cpu_addr];
    if (!rst_p && bus.cpu_we) obs_w.push_back({bus.cpu_addr, bus.cpu_dataOut});
    if (!rst_p && bus.cpu_oe) obs_r.push_back(int'(bus.cpu_addr));
    if (bus.cpu_we && bus.cpu_oe) overlap++;
  end

  // Reference screen and cursor
  logic [15:0] scr [0:2399];
  logic [31:0] exp_w[$];
  int          exp_r[$];
  int          mrow = 0, mcol = 0;
  int          w_base = 0, r_base = 0;
  int          checks = 0, errors = 0;
  int          busy_cycles;

  task automatic mput(input int a, input logic [15:0] d);
    exp_w.push_back({16'(a), d});
    scr[a] = d;
  endtask

  task automatic mscroll();
    for (int s = 80; s < 2400; s++) begin
      exp_r.push_back(s);
      mput(s - 80, scr[s]);
    end
    for (int a = 2320; a < 2400; a++) mput(a, 16'h0720);
  endtask

  task automatic mclear();
    for (int a = 0; a < 2400; a++) mput(a, 16'h0720);
    mrow = 0;
    mcol = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [7:0] a);
    exp_w.delete();
    exp_r.delete();
    if (b >= 8'h20) begin
      mput(mrow * 80 + mcol, {a, b});
      mcol++;
      if (mcol == 80) begin
        mcol = 0;
        mrow++;
        if (mrow == 30) begin mrow = 29; mscroll(); end
      end
    end else begin
      case (b)
        8'h0D: mcol = 0;
        8'h0A: begin
          mrow++;
          if (mrow == 30) begin mrow = 29; mscroll(); end
        end
        8'h08: if (mcol > 0) begin mcol--; mput(mrow * 80 + mcol, 16'h0720); end
        8'h0C: mclear();
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_op(input string tag);
    int bad;
    int nw, nr;
    nw = obs_w.size() - w_base;
    nr = obs_r.size() - r_base;
    bad = 0;
    if (nw != exp_w.size()) bad++;
    else for (int i = 0; i < nw; i++) if (obs_w[w_base + i] !== exp_w[i]) bad++;
    checks++;
    assert (bad === 0) else begin
      errors++;
      $error("FAIL %s writes: observed %0d writes (%0d bad), expected %0d", tag, nw, bad, exp_w.size());
    end
    bad = 0;
    if (nr != exp_r.size()) bad++;
    else for (int i = 0; i < nr; i++) if (obs_r[r_base + i] !== exp_r[i]) bad++;
    checks++;
    assert (bad === 0) else begin
      errors++;
      $error("FAIL %s reads: observed %0d reads (%0d bad), expected %0d", tag, nr, bad, exp_r.size());
    end
    bad = 0;
    for (int i = 0; i < 2400; i++) if (mem[i] !== scr[i]) bad++;
    checks++;
    assert (bad === 0) else begin
      errors++;
      $error("FAIL %s screen: observed %0d differing cells, expected 0", tag, bad);
    end
    checks++;
    assert ({cursor_col, cursor_row} === {7'(mcol), 5'(mrow)}) else begin
      errors++;
      $error("FAIL %s cursor: observed (%0d,%0d) expected (%0d,%0d)", tag, cursor_col, cursor_row, mcol, mrow);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!bus.char_ready && n < LIMIT) begin tick(); n++; end
    checks++;
    assert (n < LIMIT) else begin
      errors++;
      $error("FAIL %s timeout: ready low %0d cycles, expected < %0d", tag, n, LIMIT);
    end
  endtask

  task automatic accept(input logic [7:0] b, input logic [7:0] a);
    int n;
    wait_ready("accept", n);
    w_base = obs_w.size();
    r_base = obs_r.size();
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    bus.char_attr  = a;
    tick();
    bus.char_valid = 1'b0;
    bus.char_data  = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] a, input string tag);
    accept(b, a);
    wait_ready(tag, busy_cycles);
    model_byte(b, a);
    check_op(tag);
  endtask

  task automatic rand_print(input string tag);
    send(8'($urandom_range(32, 255)), 8'($urandom), tag);
  endtask

  initial begin
    int n, bad, r;
    logic [7:0] b;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.char_attr  = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("reset_ready", bus.char_ready, 0);
    chk("reset_we_oe", {bus.cpu_we, bus.cpu_oe}, 0);
    chk("reset_addr", bus.cpu_addr, 0);
    chk("reset_data", bus.cpu_dataOut, 0);
    chk("reset_cursor", {cursor_col, cursor_row}, 0);
    rst_p = 1'b0;
    exp_w.delete();
    exp_r.delete();
    mclear();
    wait_ready("reset_clear", n);
    check_op("reset_clear");
    chk("clear_ready", bus.char_ready, 1);

    // Single printable
    send(8'h41, 8'h1F, "put_A");
    chk("put_A_data", obs_w[obs_w.size() - 1], 32'h0000_1F41);
    chk("put_A_ready_low", busy_cycles, 1);

    // Line wrap from (79,5), then CR/LF
    send(8'h0D, 8'h00, "cr0");
    for (int i = 0; i < 5; i++) send(8'h0A, 8'h00, "lf_to_5");
    for (int i = 0; i < 79; i++) rand_print("fill_row5");
    send(8'h5A, 8'h4E, "put_Z_wrap");
    chk("put_Z_addr", obs_w[obs_w.size() - 1], {16'd479, 16'h4E5A});
    chk("put_Z_cursor", {cursor_col, cursor_row}, {7'd0, 5'd6});
    send(8'h0D, 8'h00, "cr");
    send(8'h0A, 8'h00, "lf");
    chk("crlf_cursor", {cursor_col, cursor_row}, {7'd0, 5'd7});

    // Form feed and backspace boundaries
    send(8'h0C, 8'h00, "ff");
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00, "lf_to_3");
    send(8'h08, 8'h00, "bs_col0");
    chk("bs_col0_nowrite", obs_w.size() - w_base, 0);
    for (int i = 0; i < 5; i++) rand_print("fill_row3");
    send(8'h08, 8'h00, "bs_col5");
    chk("bs_col5_write", obs_w[obs_w.size() - 1], {16'd244, 16'h0720});
    chk("bs_col5_cursor", {cursor_col, cursor_row}, {7'd4, 5'd3});

    // Scroll by LF on the last row, then by wrap on the last row
    send(8'h0D, 8'h00, "cr3");
    for (int i = 0; i < 26; i++) send(8'h0A, 8'h00, "lf_to_29");
    send(8'h0A, 8'h00, "lf_scroll");
    chk("lf_scroll_reads", obs_r.size() - r_base, 2320);
    chk("lf_scroll_cursor", {cursor_col, cursor_row}, {7'd0, 5'd29});
    for (int i = 0; i < 80; i++) rand_print("wrap_scroll");
    chk("wrap_scroll_cursor", {cursor_col, cursor_row}, {7'd0, 5'd29});

    // Random mix from a clean screen
    send(8'h0C, 8'h00, "ff2");
    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 62)      b = 8'($urandom_range(32, 255));
      else if (r < 70) b = 8'h0D;
      else if (r < 78) b = 8'h0A;
      else if (r < 90) b = 8'h08;
      else begin
        b = 8'($urandom_range(0, 31));
        if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h1B;
      end
      send(b, 8'($urandom), "random");
    end

    // Reset in the middle of a scroll
    send(8'h0D, 8'h00, "cr_pre_reset");
    while (mrow < 29) send(8'h0A, 8'h00, "lf_pre_reset");
    accept(8'h0A, 8'h00);
    repeat (100) tick();
    chk("mid_scroll_busy", busy, 1);
    rst_p = 1'b1;
    tick();
    chk("mid_scroll_reset_quiet", {bus.cpu_we, bus.cpu_oe, bus.char_ready}, 0);
    tick();
    rst_p = 1'b0;
    w_base = obs_w.size();
    r_base = obs_r.size();
    exp_w.delete();
    exp_r.delete();
    mclear();
    wait_ready("mid_scroll_reset", n);
    check_op("mid_scroll_reset");

    // Write gating by vertical blanking
    send(8'h41, 8'h07, "pre_vblank");
`ifdef VBLANK_SYNC_EN
    vBlank = 1'b0;
    repeat (3) tick();
    accept(8'h42, 8'h2E);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.cpu_we !== 1'b0 || bus.cpu_addr !== 16'(mrow * 80 + mcol) ||
          bus.cpu_dataOut !== 16'h2E42) bad++;
      tick();
    end
    chk("vblank_stall", bad, 0);
    vBlank = 1'b1;
    n = 0;
    while (!bus.cpu_we && n < 10) begin tick(); n++; end
    chk("vblank_release_delay", (n >= 2 && n <= 3), 1);
    chk("vblank_release_data", {bus.cpu_addr, bus.cpu_dataOut}, {16'(mrow * 80 + mcol), 16'h2E42});
    wait_ready("vblank_put", n);
    model_byte(8'h42, 8'h2E);
    check_op("vblank_put");
`else
    vBlank = 1'b0;
    send(8'h42, 8'h2E, "vblank_ignored");
    chk("vblank_ignored_ready_low", busy_cycles, 1);
    vBlank = 1'b1;
`endif

    chk("we_oe_exclusive", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Upstream feeder for the VGA character generator's CPU-side text RAM port.
- Accepts a byte stream (valid/ready) and maintains a cursor.
- Interprets control codes (CR, LF, BS, FF); performs hardware scroll by read-modify-copy through the RAM port.
- Emits 16-bit cells {attr[7:0], char[7:0]} at linear address row*N_COL+col.

Parameters:
- N_COL, 80, text columns (640/FONT_W 8)
- N_ROW, 30, text rows (480/FONT_H 16)
- CLEAR_ATTR, 8'h07, attribute used for clear/scroll fill
- READ_LATENCY, 1, cycles from cpu_oe+addr to valid cpu_dataIn

Ports:
- cpu_clk  in  1  single clock, shared with the text RAM CPU port
- rst_p  in  1  synchronous, active-high reset
- char_valid  in  1  input byte valid
- char_ready  out  1  block can accept a byte this cycle
- char_data  in  8  input byte
- char_attr  in  8  attribute for this byte, sampled with char_data
- vBlank  in  1  vertical blanking from the generator (pixel domain)
- cpu_addr  out  16  RAM address
- cpu_we  out  1  write strobe, one cycle per cell
- cpu_oe  out  1  read strobe
- cpu_dataOut  out  16  write data to RAM
- cpu_dataIn  in  16  read data from RAM
- cursor_col  out  7  current column
- cursor_row  out  5  current row
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: cpu_we=0, cpu_oe=0, cpu_addr=0, cpu_dataOut=0, cursor=(0,0), char_ready=0; FSM enters CLEAR_ALL.
- States: IDLE, PUT, CLEAR_ALL, SCROLL_RD, SCROLL_WAIT, SCROLL_WR, CLEAR_ROW.
- IDLE: char_ready=1. Transfer when char_valid&&char_ready; byte and attr are latched. char_ready is 0 in every other state.
- Printable (>=0x20): PUT next cycle: cpu_we=1, addr=cursor, data={attr,char}. Then col+1; if col==N_COL-1: col=0, row+1. If row was N_ROW-1: SCROLL_RD, else IDLE. Throughput is 1 byte per 2 cycles.
- 0x0D CR: col=0 the cycle after acceptance; no RAM access.
- 0x0A LF: row+1; at row N_ROW-1 go to SCROLL_RD; col is unchanged.
- 0x08 BS: if col>0, col-1 and write {CLEAR_ATTR,0x20} at the new position; at col 0 no-op.
- 0x0C FF: CLEAR_ALL, then cursor (0,0).
- Other codes <0x20: consumed and ignored; returns to IDLE next cycle.
- CLEAR_ALL: writes {CLEAR_ATTR,0x20} to addresses 0..N_COL*N_ROW-1, one per cycle, ascending.
- Scroll, per cell src = N_COL..N_COL*N_ROW-1:
  - SCROLL_RD: cpu_oe=1, addr=src.
  - SCROLL_WAIT: READ_LATENCY-1 cycles.
  - SCROLL_WR: cpu_we=1, addr=src-N_COL, data=cpu_dataIn.
  - Then CLEAR_ROW fills the last row with the clear cell. Cursor ends at row N_ROW-1; col is unchanged (0 after a wrap).
- Cursor is held as a linear address register updated incrementally: no multiplier, and (row,col) stays consistent with it.
- cpu_we and cpu_oe are never asserted together.
- Reset mid-scroll or mid-clear abandons the operation immediately and restarts CLEAR_ALL.
- char_valid during busy is ignored; no loss, since ready=0.

Optional Feature:
- Macro VBLANK_SYNC_EN.
- Defined: vBlank passes through a 2-flop synchroniser into cpu_clk. Any state that would assert cpu_we stalls, holding addr/data with cpu_we=0, until synced vBlank=1. Reads are not gated.
- Undefined: vBlank is unused; writes issue immediately. Mid-draw corruption is accepted and self-heals next frame.

Decomposition:
- Package vga_text_pkg: control code constants (CC_CR, CC_LF, CC_BS, CC_FF), SPACE_CHAR, state encoding, cell-pack helper.
- Sub-module vblank_sync: 2-flop synchroniser, instantiated only under VBLANK_SYNC_EN.

Test Plan:
- Reset release -> 2400 writes of 16'h0720 to addresses 0..2399; then char_ready=1 and cursor=(0,0).
- Send 'A' with attr 0x1F at (0,0) -> one write addr 0, data 16'h1F41; cursor (1,0); char_ready low for exactly 1 cycle.
- Cursor (79,5), send 'Z' -> write addr 479; cursor (0,6). Then send CR, LF -> cursor (0,7); no RAM writes.
- Cursor (0,29), send LF -> reads 80..2399, each copied to addr-80; addr 2320..2399 become 16'h0720; cursor (0,29).
- BS at (0,3) -> no write; BS at (5,3) -> write addr 244 with 16'h0720; cursor (4,3).
- With VBLANK_SYNC_EN and vBlank=0, send 'B' -> cpu_we stays 0; raise vBlank -> write occurs 2-3 cycles later with data held stable.
